random_range_sampler: RTL and testbench
=======================================

RANDOM_RANGE_SAMPLER -- requirements
Module: random_range_sampler

Interface
REQ-001 Parameter OUT_WIDTH, default 16: sample width; four OUT_WIDTH slices of the 64-bit random word.
REQ-002 Parameter FIFO_DEPTH, default 4: number of accepted-sample buffer entries; power of two.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 n_rst  input  1  reset, asynchronous assert, active-low.
REQ-005 rand_in  input  64  free-running pseudo-random word from the upstream xorshift generator; new value every cycle; no valid.
REQ-006 cfg_valid  input  1  new range request.
REQ-007 cfg_range  input  OUT_WIDTH  exclusive upper bound N; 0 means 2^OUT_WIDTH.
REQ-008 cfg_ready  output  1  config accepted when cfg_valid && cfg_ready.
REQ-009 out_value  output  OUT_WIDTH  uniform sample in [0, N).
REQ-010 out_valid  output  1  out_value valid (FIFO not empty).
REQ-011 out_ready  input  1  consumer takes sample when out_valid && out_ready.
REQ-012 reject_count  output  32  cycles in RUN with FIFO not full and no slice accepted; saturating.

Function
REQ-013 FSM states: IDLE (no range loaded), MASK (mask computation), RUN (sampling).
REQ-014 cfg_ready SHALL be 1 in IDLE and RUN and 0 in MASK.
REQ-015 Config handshake in IDLE or RUN: latch N, flush FIFO, clear reject_count, go to MASK at the same edge.
REQ-016 MASK lasts exactly one cycle: register mask = smallest (2^k - 1) >= N-1 (N=1 -> 0; N=0 -> all ones); go to RUN.
REQ-017 In RUN, each cycle: slice i = rand_in[16i+15:16i]; candidate_i = slice_i & mask; accepted if candidate_i < N (always true for N=0).
REQ-018 At most one push per cycle: lowest-index accepted slice is pushed.
REQ-019 Push allowed when FIFO not full, or when full and a pop occurs the same cycle.
REQ-020 Simultaneous push and pop at any occupancy: count unchanged, FIFO order preserved.
REQ-021 No push in IDLE or MASK; pops permitted in all states except the flush edge.
REQ-022 reject_count increments when in RUN, push allowed, and no slice accepted; holds at 32'hFFFF_FFFF.
REQ-023 Latency: cfg handshake at edge E0 -> MASK; E1 -> RUN; earliest push at E2; out_valid high after E2.
REQ-024 out_value SHALL be the FIFO head, registered; stable while out_valid && !out_ready.
REQ-025 Config handshake coinciding with out_ready pop: flush wins; the popped sample is the last of the old range.

Reset
REQ-026 n_rst low: state IDLE, FIFO empty, out_valid 0, out_value 0, cfg_ready 1, reject_count 0, N and mask 0, immediately and asynchronously.
REQ-027 Reset mid-RUN discards all buffered samples; no output until a new config.

Structure
REQ-028 Shared package lsd_rand_pkg: OUT_WIDTH default, FIFO_DEPTH default, FSM state encoding, slice count (4).
REQ-029 One sub-module rand_sample_fifo: synchronous FIFO with push, pop, flush, full, empty, count; async active-low reset.
REQ-030 Mask computation is a priority leading-one function inside random_range_sampler.

Verification
REQ-031 Reset then cfg N=5, out_ready=1, rand_in=64'h0007_0006_0005_0003 -> mask 3'h7, out_value 3 valid after E2, reject_count 0.
REQ-032 N=5, rand_in=64'h0007_0006_0005_0007 constant, FIFO empty -> no out_valid; reject_count +1 per RUN cycle.
REQ-033 N=1 -> mask 0, every RUN cycle pushes 0; out_ready=0 -> FIFO fills at 4, out_valid held, out_value 0, reject_count stays 0.
REQ-034 N=0, rand_in=64'h0000_0000_0000_FFFF -> out_value 16'hFFFF accepted.
REQ-035 FIFO full of N=5 samples, cfg N=3 with out_ready=1 same cycle -> one old sample popped, FIFO flushed, next valid samples all < 3.
REQ-036 Assert n_rst low mid-RUN with 3 samples buffered -> out_valid 0 asynchronously; after release state IDLE, cfg_ready 1.

Source files
------------

// File: rtl/lsd_rand_pkg.sv
// lsd_rand_pkg: shared constants for the random range sampler slice.
//   OUT_WIDTH_DEF  - default sample width
//   FIFO_DEPTH_DEF - default accepted-sample buffer depth (power of two)
//   NUM_SLICES     - number of OUT_WIDTH slices taken from each 64-bit random word
//   ST_*           - sampler FSM state encoding
package lsd_rand_pkg;

    localparam int unsigned OUT_WIDTH_DEF  = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned NUM_SLICES     = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;  // no range loaded
    localparam logic [1:0] ST_MASK = 2'd1;  // one-cycle mask computation
    localparam logic [1:0] ST_RUN  = 2'd2;  // sampling

endpackage

// File: rtl/rand_sample_fifo.sv
// rand_sample_fifo: synchronous FIFO for accepted samples.
//   clock, n_rst     - clock and asynchronous active-low reset
//   push, push_data  - write request; honoured when not full or when popping the same cycle
//   pop              - read request; ignored when empty
//   flush            - empties the FIFO; overrides push and pop
//   head             - registered entry at the read pointer
//   full, empty      - occupancy flags
//   count            - current number of entries
module rand_sample_fifo
    import lsd_rand_pkg::*;
#(
    parameter int unsigned WIDTH = OUT_WIDTH_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees the head slot this edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/random_range_sampler.sv
// random_range_sampler: rejection sampler producing uniform values in [0, N).
//   clock, n_rst        - clock and asynchronous active-low reset
//   rand_in             - free-running 64-bit random word, new value each cycle
//   cfg_valid/cfg_ready - range request handshake; cfg_range = N (0 means 2^OUT_WIDTH)
//   out_value/out_valid - FIFO head and non-empty flag
//   out_ready           - consumer pop
//   reject_count        - saturating count of RUN cycles with room but no accepted slice
module random_range_sampler
    import lsd_rand_pkg::*;
#(
    parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic [63:0]          rand_in,
    input  logic                 cfg_valid,
    input  logic [OUT_WIDTH-1:0] cfg_range,
    output logic                 cfg_ready,
    output logic [OUT_WIDTH-1:0] out_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          reject_count
);

    // Smallest 2^k-1 covering N-1. N=0 wraps N-1 to all ones, giving a full mask.
    function automatic logic [OUT_WIDTH-1:0] range_mask(input logic [OUT_WIDTH-1:0] n);
        logic [OUT_WIDTH-1:0] limit;
        logic [OUT_WIDTH-1:0] ones;
        logic [OUT_WIDTH-1:0] m;
        limit = n - 1'b1;
        ones  = '1;
        m     = '0;
        // Later (higher) set bits override earlier ones: leading-one priority.
        for (int i = 0; i < int'(OUT_WIDTH); i++) begin
            if (limit[i]) begin
                m = ones >> (OUT_WIDTH - 1 - i);
            end
        end
        return m;
    endfunction

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [OUT_WIDTH-1:0] range_q;
    logic [OUT_WIDTH-1:0] mask_q;
    logic [31:0]          reject_q;

    logic                 cfg_fire;
    logic                 pop;
    logic                 push_ok;
    logic                 push;
    logic                 any_acc;
    logic [OUT_WIDTH-1:0] sel;
    logic [OUT_WIDTH-1:0] cand;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                 unused_fifo_count;

    assign cfg_ready    = (state_q != ST_MASK);
    assign cfg_fire     = cfg_valid && cfg_ready;
    // A config handshake flushes the FIFO, so the FIFO itself sees no pop that edge.
    assign pop          = out_valid && out_ready && !cfg_fire;
    assign push_ok      = (state_q == ST_RUN) && !cfg_fire && (!fifo_full || pop);
    assign push         = push_ok && any_acc;
    assign out_valid    = !fifo_empty;
    assign reject_count = reject_q;
    assign unused_fifo_count = ^fifo_count;

    // Scan from the top slice down so the lowest accepted index wins.
    always_comb begin
        any_acc = 1'b0;
        sel     = '0;
        cand    = '0;
        for (int i = int'(NUM_SLICES) - 1; i >= 0; i--) begin
            cand = rand_in[i*OUT_WIDTH +: OUT_WIDTH] & mask_q;
            if (range_q == '0 || cand < range_q) begin
                any_acc = 1'b1;
                sel     = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (cfg_fire) begin
            state_d = ST_MASK;
        end else if (state_q == ST_MASK) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            range_q  <= '0;
            mask_q   <= '0;
            reject_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_MASK) begin
                mask_q <= range_mask(range_q);
            end
            if (cfg_fire) begin
                range_q  <= cfg_range;
                reject_q <= '0;
            end else if (push_ok && !any_acc && reject_q != 32'hFFFF_FFFF) begin
                reject_q <= reject_q + 32'd1;
            end
        end
    end

    rand_sample_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .n_rst     (n_rst),
        .push      (push),
        .push_data (sel),
        .pop       (pop),
        .flush     (cfg_fire),
        .head      (out_value),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_random_range_sampler.sv
module tb_random_range_sampler;

    localparam int DEPTH = 4;

    logic        clock;
    logic        n_rst;
    logic [63:0] rand_in;
    logic        cfg_valid;
    logic [15:0] cfg_range;
    logic        cfg_ready;
    logic [15:0] out_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] reject_count;

    int n_cmp;
    int n_bad;

    // Reference model: 0 idle, 1 mask, 2 run
    int          m_state;
    logic [15:0] m_range;
    logic [15:0] m_mask;
    logic [31:0] m_rej;
    logic [15:0] sb[$];

    random_range_sampler dut (
        .clock        (clock),
        .n_rst        (n_rst),
        .rand_in      (rand_in),
        .cfg_valid    (cfg_valid),
        .cfg_range    (cfg_range),
        .cfg_ready    (cfg_ready),
        .out_value    (out_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .reject_count (reject_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_mask(input logic [15:0] n);
        int lim;
        int m;
        lim = (n == 16'd0) ? 65535 : int'(n) - 1;
        m = 0;
        while (m < lim) m = m * 2 + 1;
        return m[15:0];
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_range = '0;
        m_mask  = '0;
        m_rej   = '0;
        sb.delete();
    endtask

    task automatic model_edge();
        bit          fire;
        bit          do_pop;
        bit          room;
        bit          found;
        logic [15:0] c;
        logic [15:0] pick;
        fire   = cfg_valid && (m_state != 1);
        do_pop = out_ready && (sb.size() != 0) && !fire;
        if (fire) begin
            sb.delete();
            m_rej   = '0;
            m_range = cfg_range;
            m_state = 1;
        end else begin
            room = (sb.size() < DEPTH) || do_pop;
            if (do_pop) void'(sb.pop_front());
            if (m_state == 1) begin
                m_mask  = model_mask(m_range);
                m_state = 2;
            end else if (m_state == 2 && room) begin
                found = 0;
                pick  = '0;
                for (int i = 0; i < 4; i++) begin
                    c = rand_in[16*i +: 16] & m_mask;
                    if (!found && (m_range == 0 || c < m_range)) begin
                        found = 1;
                        pick  = c;
                    end
                end
                if (found) sb.push_back(pick);
                else if (m_rej != 32'hFFFF_FFFF) m_rej = m_rej + 1;
            end
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) check("out_value", 64'(out_value), 64'(sb[0]));
        check("reject_count", 64'(reject_count), 64'(m_rej));
        check("cfg_ready", 64'(cfg_ready), 64'(m_state != 1));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_rst = 1'b0;
        rand_in = '0;
        cfg_valid = 1'b0;
        cfg_range = '0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_value", 64'(out_value), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_reject", 64'(reject_count), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_rst = 1'b1;

        // N=5 with an accepted slice 0
        rand_in   = 64'h0007_0006_0005_0003;
        out_ready = 1'b1;
        cfg_valid = 1'b1;
        cfg_range = 16'd5;
        step();
        cfg_valid = 1'b0;
        step();
        check("mask_n5", 64'(dut.mask_q), 64'h7);
        step();
        check("first_sample", 64'(out_value), 64'd3);
        repeat (3) step();

        // All four slices rejected for N=5
        rand_in = 64'h0007_0006_0005_0007;
        repeat (6) step();
        check("reject_after_drain", 64'(reject_count), 64'd6);

        // N=0 accepts everything
        rand_in   = 64'h0000_0000_0000_FFFF;
        cfg_valid = 1'b1;
        cfg_range = 16'd0;
        step();
        cfg_valid = 1'b0;
        repeat (3) step();
        check("full_range_value", 64'(out_value), 64'hFFFF);

        // N=1, consumer stalled: FIFO fills with zeros
        rand_in   = 64'h1234_5678_9ABC_DEF0;
        out_ready = 1'b0;
        cfg_valid = 1'b1;
        cfg_range = 16'd1;
        step();
        cfg_valid = 1'b0;
        step();
        check("mask_n1", 64'(dut.mask_q), 64'h0);
        repeat (7) step();

        // Fill with ordered N=5 samples 0..3, then one full-occupancy push+pop
        cfg_valid = 1'b1;
        cfg_range = 16'd5;
        step();
        cfg_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            rand_in = {48'h0007_0006_0005, 16'(k)};
            step();
        end
        rand_in = 64'h0007_0006_0005_0004;
        step();
        out_ready = 1'b1;
        step();
        check("order_head", 64'(out_value), 64'd1);

        // Reconfigure to N=3 on the same edge as a pop
        cfg_valid = 1'b1;
        cfg_range = 16'd3;
        step();
        check("flush_empty", 64'(out_valid), 64'd0);
        cfg_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            rand_in = {$urandom, $urandom};
            step();
            if (sb.size() != 0) check("below_three", 64'(out_value < 16'd3), 64'd1);
        end

        // Buffer exactly three samples, then reset asynchronously
        out_ready = 1'b0;
        rand_in   = 64'h0003_0003_0003_0001;
        for (int k = 0; k < 8 && sb.size() < 3; k++) step();
        check("three_buffered", 64'(sb.size()), 64'd3);
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_cfg_ready", 64'(cfg_ready), 64'd1);
        check("async_reject", 64'(reject_count), 64'd0);
        @(negedge clock);
        n_rst = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
